// File: rtl/instr_encoder.sv
// instr_encoder: packs MIPS-style instruction fields into 32-bit words
// and streams them, one at a time, into a DEPTH-word instruction memory.
//
// Ports
//   Clk, Rst          clock, asynchronous active-high reset
//   Start             one-cycle pulse: clear address/count/Error, arm intake
//   ReqValid/ReqReady field-set request handshake
//   ReqOpcode..ReqImm instruction fields of the request
//   Instruction       encoded word
//   InstrAddr         byte address of Instruction
//   InstrValid/InstrReady memory write handshake
//   WordCount         words written since Start
//   Full              WordCount == DEPTH
//   Error             sticky: unsupported opcode seen since Start
module instr_encoder #(
  parameter int unsigned DEPTH = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0,
  localparam int unsigned CW = $clog2(DEPTH) + 1
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          Start,
  input  logic          ReqValid,
  output logic          ReqReady,
  input  logic [5:0]    ReqOpcode,
  input  logic [5:0]    ReqFunct,
  input  logic [4:0]    ReqRs,
  input  logic [4:0]    ReqRt,
  input  logic [4:0]    ReqRd,
  input  logic [4:0]    ReqShamt,
  input  logic [15:0]   ReqImm,
  output logic [31:0]   Instruction,
  output logic [31:0]   InstrAddr,
  output logic          InstrValid,
  input  logic          InstrReady,
  output logic [CW-1:0] WordCount,
  output logic          Full,
  output logic          Error
);

  typedef enum logic [1:0] {
    IDLE,
    ACCEPT,
    HOLD,
    FULL
  } state_e;

  // Encoding family of the incoming opcode.
  typedef enum logic [1:0] {
    FMT_R,
    FMT_I,
    FMT_IZ,
    FMT_BAD
  } fmt_e;

  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEPTH - 1);
  localparam logic [31:0] ADDR_LAST =
    BASE_ADDR + 32'(4 * (DEPTH - 1));

  state_e        state_q, state_d;
  logic [31:0]   instr_q, instr_d;
  logic [31:0]   addr_q, addr_d;
  logic          valid_q, valid_d;
  logic [CW-1:0] count_q, count_d;
  logic          err_q, err_d;

  fmt_e        fmt;
  logic [31:0] enc;
  logic        req_hs;
  logic        out_hs;
  logic        last_word;

  // Opcode classification.
  always_comb begin
    fmt = FMT_BAD;
    unique case (ReqOpcode)
      6'b000000: fmt = FMT_R;
      6'b001000,
      6'b001100,
      6'b001101,
      6'b001110,
      6'b100011,
      6'b101011,
      6'b101000,
      6'b100000,
      6'b101001,
      6'b100001,
      6'b000100,
      6'b000101: fmt = FMT_I;
      // REGIMM: rt selects BGEZ/BLTZ and is passed through as-is.
      6'b000001: fmt = FMT_I;
      // BGTZ/BLEZ: rt field is architecturally zero.
      6'b000111,
      6'b000110: fmt = FMT_IZ;
      default:   fmt = FMT_BAD;
    endcase
  end

  // Field packing.
  always_comb begin
    enc = {ReqOpcode, ReqRs, ReqRt, ReqImm};
    unique case (fmt)
      FMT_R: begin
        enc = {ReqOpcode, ReqRs, ReqRt,
               ReqRd, ReqShamt, ReqFunct};
      end
      FMT_IZ: begin
        enc = {ReqOpcode, ReqRs, 5'b00000, ReqImm};
      end
      FMT_I,
      FMT_BAD: begin
        enc = {ReqOpcode, ReqRs, ReqRt, ReqImm};
      end
    endcase
  end

  assign ReqReady  = (state_q == ACCEPT) && !Start;
  assign req_hs    = ReqValid && ReqReady;
  // valid_q is only ever set in HOLD, so a stray
  // InstrReady elsewhere has no effect.
  assign out_hs    = (state_q == HOLD) && valid_q
                     && InstrReady;
  assign last_word = (count_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    addr_d  = addr_q;
    valid_d = valid_q;
    count_d = count_q;
    err_d   = err_q;
    if (Start) begin
      // Start wins over everything, including a
      // word still waiting for the memory.
      state_d = ACCEPT;
      valid_d = 1'b0;
      addr_d  = BASE_ADDR;
      count_d = '0;
      err_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = IDLE;
        end
        ACCEPT: begin
          if (req_hs) begin
            if (fmt == FMT_BAD) begin
              err_d = 1'b1;
            end else begin
              instr_d = enc;
              valid_d = 1'b1;
              state_d = HOLD;
            end
          end
        end
        HOLD: begin
          if (out_hs) begin
            valid_d = 1'b0;
            count_d = count_q + CW'(1);
            if (last_word) begin
              // Address parks on the last slot so it
              // never points past the region.
              state_d = FULL;
            end else begin
              addr_d  = addr_q + 32'd4;
              state_d = ACCEPT;
            end
          end
        end
        FULL: begin
          valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= IDLE;
      instr_q <= '0;
      addr_q  <= BASE_ADDR;
      valid_q <= 1'b0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign Instruction = instr_q;
  assign InstrAddr   = addr_q;
  assign InstrValid  = valid_q;
  assign WordCount   = count_q;
  assign Full        = (count_q == CNT_FULL);
  assign Error       = err_q;

  a_addr_bound: assert property (
    @(posedge Clk) disable iff (Rst)
    addr_q <= ADDR_LAST
  );

  a_count_bound: assert property (
    @(posedge Clk) disable iff (Rst)
    count_q <= CNT_FULL
  );

  a_valid_hold: assert property (
    @(posedge Clk) disable iff (Rst)
    valid_q |-> (state_q == HOLD)
  );

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed + randomized checks of instr_encoder
// against a word-level reference model.
module tb_instr_encoder;

  localparam int DEPTH = 4;
  localparam logic [31:0] BASE = 32'h0;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        Start = 1'b0;
  logic        ReqValid = 1'b0;
  logic        ReqReady;
  logic [5:0]  ReqOpcode = '0;
  logic [5:0]  ReqFunct = '0;
  logic [4:0]  ReqRs = '0;
  logic [4:0]  ReqRt = '0;
  logic [4:0]  ReqRd = '0;
  logic [4:0]  ReqShamt = '0;
  logic [15:0] ReqImm = '0;
  logic [31:0] Instruction;
  logic [31:0] InstrAddr;
  logic        InstrValid;
  logic        InstrReady = 1'b0;
  logic [2:0]  WordCount;
  logic        Full;
  logic        Error;

  instr_encoder #(
    .DEPTH(DEPTH),
    .BASE_ADDR(BASE)
  ) dut (
    .Clk(Clk),
    .Rst(Rst),
    .Start(Start),
    .ReqValid(ReqValid),
    .ReqReady(ReqReady),
    .ReqOpcode(ReqOpcode),
    .ReqFunct(ReqFunct),
    .ReqRs(ReqRs),
    .ReqRt(ReqRt),
    .ReqRd(ReqRd),
    .ReqShamt(ReqShamt),
    .ReqImm(ReqImm),
    .Instruction(Instruction),
    .InstrAddr(InstrAddr),
    .InstrValid(InstrValid),
    .InstrReady(InstrReady),
    .WordCount(WordCount),
    .Full(Full),
    .Error(Error)
  );

  always #5 Clk = ~Clk;

  int vecs = 0;
  int errs = 0;

  // Reference model: started flag, pending word,
  // words written, sticky error.
  bit          m_run;
  bit          m_valid;
  bit          m_err;
  int          m_words;
  logic [31:0] m_instr;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vecs++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %08h want %08h",
               tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_run   = 1'b0;
    m_valid = 1'b0;
    m_err   = 1'b0;
    m_words = 0;
    m_instr = '0;
  endtask

  function automatic logic [31:0] m_addr();
    int slot;
    slot = (m_words < DEPTH) ? m_words : DEPTH - 1;
    return BASE + 32'(4 * slot);
  endfunction

  function automatic bit m_ready();
    return m_run && !m_valid
           && (m_words < DEPTH) && !Start;
  endfunction

  // {supported, word}
  function automatic logic [32:0] encode(
    input logic [5:0] op, input logic [4:0] rs,
    input logic [4:0] rt, input logic [4:0] rd,
    input logic [4:0] sh, input logic [5:0] fn,
    input logic [15:0] imm);
    int o;
    o = int'(op);
    if (o == 0)
      return {1'b1, op, rs, rt, rd, sh, fn};
    if (o inside {8, 12, 13, 14, 35, 43, 40,
                  32, 41, 33, 4, 5, 1})
      return {1'b1, op, rs, rt, imm};
    if (o == 7 || o == 6)
      return {1'b1, op, rs, 5'd0, imm};
    return 33'd0;
  endfunction

  task automatic check_all();
    chk("ReqReady", 32'(ReqReady), 32'(m_ready()));
    chk("InstrValid", 32'(InstrValid), 32'(m_valid));
    chk("Full", 32'(Full), 32'(m_words == DEPTH));
    chk("Error", 32'(Error), 32'(m_err));
    chk("WordCount", 32'(WordCount), 32'(m_words));
    chk("InstrAddr", InstrAddr, m_addr());
    if (m_valid)
      chk("Instruction", Instruction, m_instr);
  endtask

  // One clock: check at negedge, advance model at posedge,
  // return 1ns after the edge for new stimulus.
  task automatic step();
    bit rh;
    bit oh;
    logic [32:0] e;
    @(negedge Clk);
    if (Rst) model_reset();
    check_all();
    rh = ReqValid && m_ready();
    oh = InstrReady && m_valid;
    e = encode(ReqOpcode, ReqRs, ReqRt, ReqRd,
               ReqShamt, ReqFunct, ReqImm);
    @(posedge Clk);
    if (Rst) begin
      model_reset();
    end else if (Start) begin
      m_run   = 1'b1;
      m_valid = 1'b0;
      m_words = 0;
      m_err   = 1'b0;
    end else if (oh) begin
      m_valid = 1'b0;
      m_words++;
    end else if (rh) begin
      if (e[32]) begin
        m_valid = 1'b1;
        m_instr = e[31:0];
      end else begin
        m_err = 1'b1;
      end
    end
    #1;
  endtask

  task automatic set_req(input logic [5:0] op,
                         input logic [4:0] rs,
                         input logic [4:0] rt,
                         input logic [4:0] rd,
                         input logic [4:0] sh,
                         input logic [5:0] fn,
                         input logic [15:0] imm);
    ReqOpcode = op;
    ReqRs     = rs;
    ReqRt     = rt;
    ReqRd     = rd;
    ReqShamt  = sh;
    ReqFunct  = fn;
    ReqImm    = imm;
  endtask

  task automatic pulse_start();
    Start = 1'b1;
    step();
    Start = 1'b0;
  endtask

  logic [5:0] ops [19] = '{
    6'd0, 6'd8, 6'd12, 6'd13, 6'd14, 6'd35, 6'd43,
    6'd40, 6'd32, 6'd41, 6'd33, 6'd4, 6'd5, 6'd1,
    6'd7, 6'd6, 6'd63, 6'd2, 6'd9
  };

  initial begin
    model_reset();
    // Reset state
    step();
    step();
    chk("rst_instr", Instruction, 32'h0);
    chk("rst_addr", InstrAddr, BASE);
    Rst = 1'b0;
    ReqValid = 1'b1;
    step();
    step();
    chk("idle_ready", 32'(ReqReady), 32'h0);
    ReqValid = 1'b0;

    // ADDI with immediate memory accept
    pulse_start();
    set_req(6'b001000, 5'd1, 5'd2, 5'd0, 5'd0,
            6'd0, 16'h0005);
    ReqValid = 1'b1;
    InstrReady = 1'b1;
    step();
    ReqValid = 1'b0;
    chk("addi_word", Instruction, 32'h20220005);
    chk("addi_valid", 32'(InstrValid), 32'h1);
    chk("addi_addr", InstrAddr, 32'h0);
    step();
    chk("addi_count", 32'(WordCount), 32'h1);

    // R-type with memory back-pressure
    pulse_start();
    InstrReady = 1'b0;
    set_req(6'b000000, 5'd1, 5'd2, 5'd3, 5'd0,
            6'b100000, 16'h0);
    ReqValid = 1'b1;
    step();
    ReqValid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("r_word", Instruction, 32'h00221820);
      chk("r_ready", 32'(ReqReady), 32'h0);
      step();
    end
    InstrReady = 1'b1;
    step();
    chk("r_addr", InstrAddr, 32'h4);
    chk("r_valid", 32'(InstrValid), 32'h0);

    // BGTZ forces rt to zero
    pulse_start();
    InstrReady = 1'b0;
    set_req(6'b000111, 5'd4, 5'd7, 5'd0, 5'd0,
            6'd0, 16'hFFFE);
    ReqValid = 1'b1;
    step();
    ReqValid = 1'b0;
    chk("bgtz_word", Instruction, 32'h1C80FFFE);

    // Unsupported opcode
    pulse_start();
    InstrReady = 1'b1;
    set_req(6'b111111, 5'd1, 5'd2, 5'd3, 5'd4,
            6'd5, 16'h1234);
    ReqValid = 1'b1;
    step();
    chk("bad_err", 32'(Error), 32'h1);
    chk("bad_valid", 32'(InstrValid), 32'h0);
    chk("bad_count", 32'(WordCount), 32'h0);
    set_req(6'b001000, 5'd1, 5'd2, 5'd0, 5'd0,
            6'd0, 16'h0005);
    step();
    ReqValid = 1'b0;
    chk("bad_next", Instruction, 32'h20220005);
    step();
    chk("bad_cnt1", 32'(WordCount), 32'h1);
    chk("bad_sticky", 32'(Error), 32'h1);
    pulse_start();
    chk("bad_clr", 32'(Error), 32'h0);

    // Fill all DEPTH words
    pulse_start();
    InstrReady = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      set_req(6'b001101, 5'(i), 5'd9, 5'd0, 5'd0,
              6'd0, 16'(i * 3));
      ReqValid = 1'b1;
      step();
      ReqValid = 1'b0;
      chk("fill_addr", InstrAddr, 32'(4 * i));
      step();
    end
    chk("fill_full", 32'(Full), 32'h1);
    ReqValid = 1'b1;
    step();
    step();
    chk("full_ready", 32'(ReqReady), 32'h0);
    chk("full_valid", 32'(InstrValid), 32'h0);
    pulse_start();
    ReqValid = 1'b0;
    chk("restart_full", 32'(Full), 32'h0);
    chk("restart_addr", InstrAddr, 32'h0);
    chk("restart_cnt", 32'(WordCount), 32'h0);
    chk("restart_vld", 32'(InstrValid), 32'h0);

    // Asynchronous reset with a word pending
    InstrReady = 1'b0;
    set_req(6'b001000, 5'd3, 5'd4, 5'd0, 5'd0,
            6'd0, 16'h00AA);
    ReqValid = 1'b1;
    step();
    ReqValid = 1'b0;
    chk("pre_rst_vld", 32'(InstrValid), 32'h1);
    #2;
    Rst = 1'b1;
    InstrReady = 1'b1;
    #1;
    chk("arst_vld", 32'(InstrValid), 32'h0);
    chk("arst_instr", Instruction, 32'h0);
    chk("arst_addr", InstrAddr, BASE);
    chk("arst_ready", 32'(ReqReady), 32'h0);
    chk("arst_cnt", 32'(WordCount), 32'h0);
    chk("arst_full", 32'(Full), 32'h0);
    chk("arst_err", 32'(Error), 32'h0);
    model_reset();
    step();
    Rst = 1'b0;
    step();
    step();

    // Randomized traffic
    repeat (3000) begin
      Rst = ($urandom_range(0, 249) == 0);
      Start = ($urandom_range(0, 29) == 0);
      ReqValid = $urandom_range(0, 1) != 0;
      InstrReady = $urandom_range(0, 2) != 0;
      if ($urandom_range(0, 9) == 0)
        ReqOpcode = 6'($urandom);
      else
        ReqOpcode = ops[$urandom_range(0, 18)];
      ReqRs    = 5'($urandom);
      ReqRt    = 5'($urandom);
      ReqRd    = 5'($urandom);
      ReqShamt = 5'($urandom);
      ReqFunct = 6'($urandom);
      ReqImm   = 16'($urandom);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter DEPTH, 256: capacity in 32-bit words of the target instruction memory region.
REQ-002 Parameter BASE_ADDR, 32'h0: byte address of the first written word.
REQ-003 Clk  in  1  single clock; all state changes on its rising edge.
REQ-004 Rst  in  1  reset, asynchronous, active-high.
REQ-005 Start  in  1  one-cycle pulse; clears address, count and Error, then enables accept.
REQ-006 ReqValid  in  1  field-set request valid.
REQ-007 ReqReady  out  1  block accepts request this cycle.
REQ-008 ReqOpcode  in  6; ReqFunct in 6; ReqRs, ReqRt, ReqRd, ReqShamt in 5 each; ReqImm in 16: instruction fields.
REQ-009 Instruction  out  32  encoded word.
REQ-010 InstrAddr  out  32  byte address for Instruction.
REQ-011 InstrValid  out  1  Instruction/InstrAddr valid for memory write.
REQ-012 InstrReady  in  1  memory accepts word.
REQ-013 WordCount  out  clog2(DEPTH)+1  words written since Start.
REQ-014 Full  out  1  WordCount == DEPTH.
REQ-015 Error  out  1  sticky: unsupported opcode received since Start.

Function
REQ-016 States SHALL be IDLE, ACCEPT, HOLD, FULL.
REQ-017 IDLE -> ACCEPT on Start; ReqReady = (state==ACCEPT) && !Start.
REQ-018 Request handshake = ReqValid && ReqReady at a rising edge.
REQ-019 Opcode 000000: Instruction = {op, rs, rt, rd, shamt, funct}.
REQ-020 Opcodes 001000, 001100, 001101, 001110, 100011, 101011, 101000, 100000, 101001, 100001, 000100, 000101: Instruction = {op, rs, rt, imm}.
REQ-021 Opcode 000001: {op, rs, rt, imm}, rt carrying the BGEZ/BLTZ selector unchanged.
REQ-022 Opcodes 000111, 000110: {op, rs, 5'b00000, imm}; ReqRt ignored.
REQ-023 Any other opcode: handshake completes, Error set next cycle, no word emitted, state stays ACCEPT.
REQ-024 Supported handshake at edge N: Instruction registered, InstrValid=1 from cycle N+1, state HOLD.
REQ-025 In HOLD, Instruction, InstrAddr, InstrValid held stable until InstrReady=1 at an edge.
REQ-026 On output handshake: InstrAddr += 4, WordCount += 1, InstrValid=0 next cycle; next state FULL if new WordCount==DEPTH, else ACCEPT.
REQ-027 FULL: ReqReady=0, Full=1, InstrValid=0; exits only on Start or Rst.
REQ-028 Start in any state has priority: pending word discarded, InstrValid=0, InstrAddr=BASE_ADDR, WordCount=0, Error=0, Full=0, next state ACCEPT; a same-cycle ReqValid is not accepted.
REQ-029 InstrAddr SHALL never exceed BASE_ADDR+4*(DEPTH-1); no wrap-around, FULL blocks further writes.
REQ-030 InstrReady while InstrValid=0 SHALL be ignored.

Reset
REQ-031 Rst asserted SHALL immediately force state IDLE, Instruction=0, InstrAddr=BASE_ADDR, InstrValid=0, ReqReady=0, WordCount=0, Full=0, Error=0, regardless of in-flight word.
REQ-032 After Rst release, block stays IDLE until Start.

Verification
REQ-033 Start; ADDI op=001000 rs=1 rt=2 imm=0x0005, InstrReady=1 -> Instruction=0x20220005, InstrAddr=0x0, InstrValid one cycle after handshake, WordCount=1.
REQ-034 R-type rs=1 rt=2 rd=3 shamt=0 funct=100000, InstrReady low 3 cycles -> Instruction=0x00221820 stable, ReqReady=0 throughout, released on InstrReady, InstrAddr=0x4 afterwards.
REQ-035 BGTZ op=000111 rs=4 rt=7 imm=0xFFFE -> Instruction=0x1C80FFFE (rt forced 0).
REQ-036 Opcode 111111 -> Error=1, InstrValid stays 0, WordCount unchanged; following ADDI still written correctly; Start clears Error.
REQ-037 DEPTH=4: four words -> addresses 0x0,0x4,0x8,0xC, Full=1, ReqReady=0 with ReqValid held; Start -> Full=0, InstrAddr=0x0, WordCount=0.
REQ-038 Rst pulsed while HOLD with InstrValid=1 -> all outputs at reset values before next Clk edge; no write occurs.
